// File: rtl/dspi_delay_pkg.sv
// rtl/dspi_delay_pkg.sv - shared constants, lane indices and lane FSM state type for the delay block
package dspi_delay_pkg;

    // Idle encoding on every lane: data Type 0 / CMD_IDLE are both all-zero words.
    localparam logic IDLE_FILL = 1'b0;

    localparam int LANE_DIR1_DATA = 0;
    localparam int LANE_DIR2_DATA = 1;
    localparam int LANE_DIR1_CTRL = 2;
    localparam int LANE_DIR2_CTRL = 3;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } lane_state_e;

    function automatic int clamp_delay(input int requested, input int max_delay);
        if (requested < 1) begin
            return 1;
        end
        if (requested > max_delay) begin
            return max_delay;
        end
        return requested;
    endfunction

endpackage

// File: rtl/pipeline_delay_lane.sv
// rtl/pipeline_delay_lane.sv - one delay lane: circular buffer, write pointer, settle counter and FSM
module pipeline_delay_lane
    import dspi_delay_pkg::*;
#(
    parameter int LANE_WIDTH    = 600,
    parameter int MAX_DELAY     = 128,
    parameter int DEFAULT_DELAY = 100,
    parameter int DELAY_WIDTH   = $clog2(MAX_DELAY + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANE_WIDTH-1:0]  payload,
    input  logic                   load,
    input  logic [DELAY_WIDTH-1:0] load_delay,
    output logic [LANE_WIDTH-1:0]  delayed,
    output logic                   settled
);

    localparam int PTR_WIDTH = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int SUM_WIDTH = DELAY_WIDTH + 1;

    logic [LANE_WIDTH-1:0]  mem [MAX_DELAY];
    logic [PTR_WIDTH-1:0]   wptr;
    logic [PTR_WIDTH-1:0]   rptr;
    logic [SUM_WIDTH-1:0]   rd_sum;
    logic [SUM_WIDTH-1:0]   rd_wrapped;
    logic [DELAY_WIDTH-1:0] delay;
    logic [DELAY_WIDTH-1:0] count;
    logic [DELAY_WIDTH-1:0] count_next;
    lane_state_e            state;
    lane_state_e            state_next;

    // Storage is written every cycle and never reset; SETTLE masks anything stale.
    always_ff @(posedge clk) begin
        mem[wptr] <= payload;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            delay <= DELAY_WIDTH'(DEFAULT_DELAY);
            count <= DELAY_WIDTH'(DEFAULT_DELAY);
            state <= SETTLE;
        end else begin
            wptr  <= (wptr == PTR_WIDTH'(MAX_DELAY - 1)) ? '0 : wptr + PTR_WIDTH'(1);
            if (load) begin
                delay <= load_delay;
            end
            count <= count_next;
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        if (load) begin
            state_next = SETTLE;
            count_next = load_delay;
        end else if (state == SETTLE) begin
            count_next = count - DELAY_WIDTH'(1);
            if (count == DELAY_WIDTH'(1)) begin
                state_next = RUN;
            end
        end
    end

    // Read address is wptr - delay modulo MAX_DELAY; delay is always 1..MAX_DELAY.
    always_comb begin
        rd_sum     = SUM_WIDTH'(wptr) + SUM_WIDTH'(MAX_DELAY) - SUM_WIDTH'(delay);
        rd_wrapped = (rd_sum >= SUM_WIDTH'(MAX_DELAY)) ? rd_sum - SUM_WIDTH'(MAX_DELAY) : rd_sum;
        rptr       = PTR_WIDTH'(rd_wrapped);
    end

    always_comb begin
        settled = (state == RUN);
        delayed = (state == RUN) ? mem[rptr] : {LANE_WIDTH{IDLE_FILL}};
    end

endmodule

// File: rtl/programmable_pipeline_delay.sv
// rtl/programmable_pipeline_delay.sv - multi-lane programmable delay with per-lane settle masking
module programmable_pipeline_delay
    import dspi_delay_pkg::*;
#(
    parameter int  NUM_LANES     = 4,
    parameter int  LANE_WIDTH    = 600,
    parameter int  MAX_DELAY     = 128,
    parameter int  DEFAULT_DELAY = 100,
    localparam int DELAY_WIDTH   = $clog2(MAX_DELAY + 1),
    localparam int LANE_ID_WIDTH = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                            clk,
    input  logic                            rstIn,
    output logic                            rstOut,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] laneIn,
    output logic [NUM_LANES*LANE_WIDTH-1:0] laneOut,
    input  logic                            cfgValid,
    input  logic [LANE_ID_WIDTH-1:0]        cfgLane,
    input  logic [DELAY_WIDTH-1:0]          cfgDelay,
    output logic                            cfgReady,
    output logic [NUM_LANES-1:0]            laneSettled
);

    logic                   accept;
    logic [DELAY_WIDTH-1:0] clamped;

    always_ff @(posedge clk) begin
        rstOut <= rstIn;
    end

    assign cfgReady = !rstIn;
    assign accept   = cfgValid && cfgReady;
    assign clamped  = DELAY_WIDTH'(clamp_delay(int'(cfgDelay), MAX_DELAY));

    // Out-of-range lane ids simply match no lane and are dropped.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic load;
        assign load = accept && (int'(cfgLane) == k);

        pipeline_delay_lane #(
            .LANE_WIDTH    (LANE_WIDTH),
            .MAX_DELAY     (MAX_DELAY),
            .DEFAULT_DELAY (DEFAULT_DELAY),
            .DELAY_WIDTH   (DELAY_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rstIn),
            .payload    (laneIn[k*LANE_WIDTH +: LANE_WIDTH]),
            .load       (load),
            .load_delay (clamped),
            .delayed    (laneOut[k*LANE_WIDTH +: LANE_WIDTH]),
            .settled    (laneSettled[k])
        );
    end

endmodule

// File: doc/programmable_pipeline_delay.md
PROGRAMMABLE_PIPELINE_DELAY -- requirements
Module: programmable_pipeline_delay

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of independent delay lanes (dirOne data, dirTwo data, dirOne ctrl, dirTwo ctrl).
REQ-002 SHALL have parameter LANE_WIDTH, default 600, payload bits per lane.
REQ-003 SHALL have parameter MAX_DELAY, default 128, largest programmable delay in cycles (>=2).
REQ-004 SHALL have parameter DEFAULT_DELAY, default 100, per-lane delay after reset (1..MAX_DELAY).
REQ-005 SHALL have derived parameters DELAY_WIDTH=$clog2(MAX_DELAY+1) and LANE_ID_WIDTH=max(1,$clog2(NUM_LANES)).
REQ-006 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-007 SHALL have port rstIn  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port rstOut  output  1  rstIn registered once (reset value 1).
REQ-009 SHALL have port laneIn  input  NUM_LANES*LANE_WIDTH  lane k payload in bits [k*LANE_WIDTH +: LANE_WIDTH].
REQ-010 SHALL have port laneOut  output  NUM_LANES*LANE_WIDTH  delayed payloads, same packing.
REQ-011 SHALL have port cfgValid  input  1  delay-update request.
REQ-012 SHALL have port cfgLane  input  LANE_ID_WIDTH  target lane.
REQ-013 SHALL have port cfgDelay  input  DELAY_WIDTH  requested delay.
REQ-014 SHALL have port cfgReady  output  1  update accepted when cfgValid&&cfgReady.
REQ-015 SHALL have port laneSettled  output  NUM_LANES  bit k high while lane k is in RUN.

Function
REQ-016 Each lane SHALL run an independent FSM with states SETTLE and RUN plus a settle counter.
REQ-017 In RUN, lane k SHALL output laneOut_k(t) = laneIn_k(t-D_k), D_k being its current delay; D=1 equals one register stage.
REQ-018 In SETTLE, lane k SHALL drive laneOut_k all-zero (the idle encoding: data Type 0, instruction CMD_IDLE) and laneSettled[k]=0, while still writing laneIn_k into storage.
REQ-019 On entering SETTLE, the counter SHALL load D_k; it SHALL decrement once per cycle; the lane moves to RUN the cycle it reaches 0, so the first valid output equals the input sampled exactly D_k cycles after SETTLE entry.
REQ-020 Storage SHALL be a per-lane circular buffer of MAX_DELAY entries with a wrapping write pointer (MAX_DELAY-1 -> 0); read address = wptr - D_k modulo MAX_DELAY; no shift-register chain.
REQ-021 cfgReady SHALL be 1 whenever rstIn=0 and 0 during reset; at most one update per cycle.
REQ-022 An accepted update SHALL set D_k := clamp(cfgDelay, 1, MAX_DELAY) and force lane k into SETTLE on the next cycle, from either state.
REQ-023 An update to a lane already in SETTLE SHALL restart its counter with the new delay.
REQ-024 cfgLane >= NUM_LANES SHALL be accepted and ignored (no lane changes).
REQ-025 Lanes not targeted by an update SHALL be unaffected, cycle-exact.

Reset
REQ-026 While rstIn=1: every D_k := DEFAULT_DELAY, every lane in SETTLE with counter DEFAULT_DELAY, write pointers 0, laneOut all-zero, laneSettled all-zero, cfgReady=0, rstOut=1.
REQ-027 Storage contents SHALL NOT be reset (RAM-inferable); SETTLE masking guarantees no stale data ever reaches laneOut.
REQ-028 Reset asserted mid-RUN or mid-SETTLE SHALL take effect the following edge, discarding in-flight data and pending configuration.

Structure
REQ-029 Shared package dspi_delay_pkg SHALL hold the idle encoding constant, lane index constants (LANE_DIR1_DATA..LANE_DIR2_CTRL) and the FSM state typedef.
REQ-030 One sub-module, pipeline_delay_lane (storage, pointer, FSM, counter for one lane), SHALL be instantiated NUM_LANES times via generate.

Verification
REQ-031 Reset release, counting ramp on lane 0, defaults -> laneOut_0 zero for 100 cycles, then ramp value n appears at cycle n+100; laneSettled[0] rises at cycle 100.
REQ-032 In RUN, write cfgLane=1, cfgDelay=5 -> lane 1 zero for 5 cycles, then exact 5-cycle delay; lanes 0,2,3 outputs unchanged throughout.
REQ-033 cfgDelay=0 and cfgDelay=MAX_DELAY+1 -> delays 1 and 128 respectively, verified by output latency.
REQ-034 Update lane 2 to 10, then to 3 four cycles later -> settle ends 3 cycles after second update, delay 3.
REQ-035 Delay 128 with >300-cycle ramp -> correct across write-pointer wrap, no gaps or duplicates.
REQ-036 rstIn pulsed for 1 cycle mid-RUN -> next cycle all outputs zero, delays back to 100, settle repeats.
